// File: rtl/word_dispatcher_pkg.sv
// Shared lane encoding, FSM state type and dest-to-sel mapping for the dispatcher.
package dispatch_pkg;

  // Demux select codes for each output lane
  localparam logic [1:0] SEL_Y1 = 2'b01;
  localparam logic [1:0] SEL_Y2 = 2'b10;
  localparam logic [1:0] SEL_Y3 = 2'b11;
  localparam logic [1:0] SEL_Y4 = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLOCK = 2'd2
  } state_t;

  // The demux numbers its lanes one step ahead of the destination index
  function automatic logic [1:0] dest_to_sel(input logic [1:0] dest);
    logic [1:0] s;
    case (dest)
      2'd0:    s = SEL_Y1;
      2'd1:    s = SEL_Y2;
      2'd2:    s = SEL_Y3;
      default: s = SEL_Y4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/word_dispatcher_if.sv
// Producer handshake plus demux drive bus between a feeder and the dispatcher.
interface word_dispatcher_if #(
  parameter int DW = 16
) ();

  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic [1:0]    in_dest;
  logic [3:0]    lane_rdy;
  logic [DW-1:0] dout;
  logic [1:0]    sel;
  logic          el;
  logic [3:0]    lane_stb;

  // Producer / lane-consumer side
  modport master (
    output in_vld, in_data, in_dest, lane_rdy,
    input  in_rdy, dout, sel, el, lane_stb
  );

  // Dispatcher side
  modport slave (
    input  in_vld, in_data, in_dest, lane_rdy,
    output in_rdy, dout, sel, el, lane_stb
  );

endinterface

// File: rtl/word_dispatcher_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous clear.
module sync_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage array is written only on an accepted push; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two; flush wins over traffic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_dispatcher.sv
// Buffers tagged words and presents each one to the 1:4 demux for one strobed cycle.
module word_dispatcher #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic [AW:0]       count,
  word_dispatcher_if.slave  bus
);
  import dispatch_pkg::*;

  logic [DW+1:0] head;
  logic [1:0]    head_dest;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  state_t        state;
  state_t        next_state;
  logic [DW-1:0] dout_q;
  logic [1:0]    sel_q;
  logic [3:0]    stb_q;

  // A pop never frees room for a same-cycle push, so readiness looks only at full
  assign bus.in_rdy = !full && !flush && !rst;
  assign push       = bus.in_vld && bus.in_rdy;
  assign head_dest  = head[DW+1:DW];
  assign pop        = !empty && bus.lane_rdy[head_dest] && !flush;

  sync_fifo #(
    .W     (DW + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_dest, bus.in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // State register; reset forces IDLE so el rises immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: any pop leads to a DRIVE cycle, a stuck head parks in BLOCK
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (pop)                  next_state = DRIVE;
        else if (!empty && !flush) next_state = BLOCK;
      end
      DRIVE: begin
        if (pop) next_state = DRIVE;
      end
      BLOCK: begin
        if (pop)                   next_state = DRIVE;
        else if (!flush && !empty) next_state = BLOCK;
      end
      default: next_state = IDLE;
    endcase
  end

  // Data, select and strobe are captured from the head entry on each pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      sel_q  <= SEL_Y4;
      stb_q  <= '0;
    end else if (pop) begin
      dout_q <= head[DW-1:0];
      sel_q  <= dest_to_sel(head_dest);
      stb_q  <= 4'b0001 << head_dest;
    end else begin
      stb_q  <= '0;
    end
  end

  // Demux is enabled only in DRIVE, and the strobe is gated by the same state
  always_comb begin
    bus.dout     = dout_q;
    bus.sel      = sel_q;
    bus.el       = (state != DRIVE);
    bus.lane_stb = (state == DRIVE) ? stb_q : 4'b0000;
  end

endmodule

// File: tb/tb_word_dispatcher.sv
// Randomized and directed checks of word_dispatcher against a queue-based model.
module tb_word_dispatcher;

  typedef struct {
    logic [1:0]  dest;
    logic [15:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] count;
  int         total = 0;
  int         bad = 0;
  exp_t       exp_q[$];
  logic [3:0] last_lanes = 4'hF;

  word_dispatcher_if #(.DW(16)) bus ();

  word_dispatcher #(.DW(16), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .count (count),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus: drive at posedge+1, record acceptance before the edge
  task automatic apply_stimulus(input logic vld, input logic [15:0] data, input logic [1:0] dest,
                                input logic [3:0] lanes, input logic fl, output logic accepted);
    exp_t e;
    bus.in_vld   = vld;
    bus.in_data  = data;
    bus.in_dest  = dest;
    bus.lane_rdy = lanes;
    flush        = fl;
    @(negedge clk);
    #1;
    accepted = bus.in_vld && bus.in_rdy;
    if (fl) exp_q.delete();
    if (accepted) begin
      e.dest = dest;
      e.data = data;
      exp_q.push_back(e);
    end
    last_lanes = lanes;
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic idle_cycle(input logic [3:0] lanes);
    logic acc;
    apply_stimulus(1'b0, 16'h0, 2'd0, lanes, 1'b0, acc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      idle_cycle(4'hF);
    end
    check_output("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every strobe must match the oldest outstanding word
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check_output("el_low_iff_strobe", 32'(bus.el == 1'b0), 32'(bus.lane_stb != 4'b0));
      if (bus.lane_stb != 4'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_strobe actual=%b required=0000", bus.lane_stb);
        end else begin
          e = exp_q.pop_front();
          check_output("dout", 32'(bus.dout), 32'(e.data));
          check_output("sel", 32'(bus.sel), 32'((int'(e.dest) + 1) % 4));
          check_output("lane_stb", 32'(bus.lane_stb), 32'(1 << e.dest));
          check_output("lane_was_ready", 32'(last_lanes[e.dest]), 32'd1);
        end
      end
      check_output("count", 32'(count), 32'(exp_q.size()));
    end
  end

  initial begin
    logic acc;
    logic [2:0] peak;
    bus.in_vld   = 1'b0;
    bus.in_data  = '0;
    bus.in_dest  = '0;
    bus.lane_rdy = 4'hF;

    // Reset values
    #2;
    check_output("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
    check_output("rst_el", 32'(bus.el), 32'd1);
    check_output("rst_dout", 32'(bus.dout), 32'd0);
    check_output("rst_sel", 32'(bus.sel), 32'd0);
    check_output("rst_stb", 32'(bus.lane_stb), 32'd0);
    check_output("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("post_rst_in_rdy", 32'(bus.in_rdy), 32'd1);

    // Single word, latency and content
    $display("[TB] single word");
    apply_stimulus(1'b1, 16'hA5A5, 2'd3, 4'hF, 1'b0, acc);
    check_output("single_accept", 32'(acc), 32'd1);
    check_output("single_not_yet", 32'(bus.lane_stb), 32'd0);
    idle_cycle(4'hF);
    check_output("single_el", 32'(bus.el), 32'd0);
    check_output("single_sel", 32'(bus.sel), 32'd0);
    check_output("single_stb", 32'(bus.lane_stb), 32'h8);
    check_output("single_dout", 32'(bus.dout), 32'hA5A5);
    idle_cycle(4'hF);
    check_output("single_el_after", 32'(bus.el), 32'd1);

    // Four back-to-back words, one per lane
    $display("[TB] back-to-back");
    peak = '0;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 16'($urandom), 2'(i), 4'hF, 1'b0, acc);
      if (count > peak) peak = count;
      if (i > 0) check_output("b2b_stb", 32'(bus.lane_stb), 32'(1 << (i - 1)));
    end
    idle_cycle(4'hF);
    check_output("b2b_last_stb", 32'(bus.lane_stb), 32'h8);
    check_output("b2b_last_sel", 32'(bus.sel), 32'd0);
    idle_cycle(4'hF);
    check_output("b2b_peak", 32'(peak), 32'd1);

    // Head-of-line blocking
    $display("[TB] head-of-line block");
    apply_stimulus(1'b1, 16'h1111, 2'd1, 4'b1101, 1'b0, acc);
    apply_stimulus(1'b1, 16'h0000, 2'd0, 4'b1101, 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      idle_cycle(4'b1101);
      check_output("block_el", 32'(bus.el), 32'd1);
      check_output("block_stb", 32'(bus.lane_stb), 32'd0);
    end
    check_output("block_count", 32'(count), 32'd2);
    idle_cycle(4'hF);
    check_output("unblock_first", 32'(bus.lane_stb), 32'h2);
    idle_cycle(4'hF);
    check_output("unblock_second", 32'(bus.lane_stb), 32'h1);
    idle_cycle(4'hF);

    // Fill to full, reject a fifth word, then drain across the pointer wrap
    $display("[TB] fill and drain");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 16'h5000 + 16'(i), 2'($urandom), 4'h0, 1'b0, acc);
      check_output("fill_accept", 32'(acc), 32'd1);
    end
    check_output("full_in_rdy", 32'(bus.in_rdy), 32'd0);
    apply_stimulus(1'b1, 16'hDEAD, 2'd0, 4'h0, 1'b0, acc);
    check_output("fifth_rejected", 32'(acc), 32'd0);
    wait_drain();

    // Flush with words queued and a word presented
    $display("[TB] flush");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 16'h7700 + 16'(i), 2'(i), 4'h0, 1'b0, acc);
    apply_stimulus(1'b1, 16'hBEEF, 2'd2, 4'h0, 1'b1, acc);
    check_output("flush_reject", 32'(acc), 32'd0);
    check_output("flush_count", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle_cycle(4'hF);
      check_output("flush_no_stb", 32'(bus.lane_stb), 32'd0);
    end

    // Reset asserted while a word is being driven
    $display("[TB] reset mid-drive");
    apply_stimulus(1'b1, 16'h1234, 2'd2, 4'hF, 1'b0, acc);
    apply_stimulus(1'b1, 16'h5678, 2'd1, 4'hF, 1'b0, acc);
    check_output("pre_rst_el", 32'(bus.el), 32'd0);
    rst = 1'b1;
    #1;
    check_output("mid_rst_el", 32'(bus.el), 32'd1);
    check_output("mid_rst_stb", 32'(bus.lane_stb), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("after_rst_count", 32'(count), 32'd0);
    check_output("after_rst_in_rdy", 32'(bus.in_rdy), 32'd1);

    // Randomized traffic with occasional back-pressure and flush
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom),
                     ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF,
                     $urandom_range(0, 39) == 0, acc);
    end
    wait_drain();
    idle_cycle(4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/word_dispatcher.md
# word_dispatcher

Upstream feeder for the 16-bit 1:4 demux (`nbitdemux`). It accepts tagged 16-bit words over a valid/ready handshake and buffers them in a small FIFO. For each word it drives the demux data, `sel` and active-low `el` for exactly one cycle, with a matching per-lane strobe. It stalls on per-lane back-pressure, so downstream lane consumers see exactly one qualified word per strobe. The demux holds its outputs between selections, so `lane_stb` is the only valid qualifier for `y1..y4`.

## Interface
- `DW`, 16, data width; must match demux width.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `AW`, log2(DEPTH), FIFO pointer width; derived, not overridden.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_vld`  in  1  producer has a word.
- `in_rdy`  out  1  dispatcher can accept; transfer occurs on an edge where `in_vld & in_rdy`.
- `in_data`  in  DW  word payload.
- `in_dest`  in  2  destination lane index: 0→y1, 1→y2, 2→y3, 3→y4.
- `flush`  in  1  synchronous FIFO clear.
- `lane_rdy`  in  4  bit k high: lane y(k+1) can take a word this cycle.
- `dout`  out  DW  drives demux `i`.
- `sel`  out  2  drives demux `sel`.
- `el`  out  1  drives demux `el`; 0 = route, 1 = all demux outputs Z.
- `lane_stb`  out  4  one-hot strobe; bit k means y(k+1) carries a new word this cycle.
- `count`  out  AW+1  FIFO occupancy, 0..DEPTH.

## Operation
- Lane encoding is fixed by the demux: dest 0→sel 01, 1→10, 2→11, 3→00. The rule is sel = (dest+1) mod 4.
- `in_rdy` = !full & !flush & !rst. A pop does not free space for a push in the same cycle.
- Pop condition is `!empty & lane_rdy[head_dest] & !flush`. Strict head-of-line order; a blocked head blocks every later word.
- FSM states:
  - IDLE: `el`=1, `lane_stb`=0. Go to DRIVE on the pop condition.
  - DRIVE: `el`=0, exactly one strobe bit set. Stay in DRIVE on the next pop condition; otherwise return to IDLE.
  - BLOCK: head valid but its lane is not ready; outputs as IDLE. Go to DRIVE when the lane becomes ready, or to IDLE on flush.
- On each pop, `dout`/`sel` are registered from the head entry. When not driving, `dout`/`sel` hold their last values while `el`=1.
- `flush`: occupancy goes to 0 on the next edge. Pending push and pop in that cycle are discarded, and the FSM goes to IDLE.
- `count` increments on push, decrements on pop, and is unchanged on simultaneous push and pop.
- Both pointers wrap modulo DEPTH.

## Timing
- Reset values: `el`=1, `dout`=0, `sel`=00, `lane_stb`=0000, `count`=0, `in_rdy`=0 while `rst` is high, FSM=IDLE, pointers=0.
- Reset asserted mid-DRIVE: `el` goes to 1 and `lane_stb` to 0 immediately (asynchronous). Buffered words are lost.
- Latency: a word pushed at edge E0 into an empty FIFO, with its lane ready, is driven in the cycle after edge E1 (`el`=0, strobe high).
- Throughput: 1 word/cycle while lanes stay ready; back-to-back DRIVE cycles are allowed, with no gap.
- All outputs are registered except `in_rdy`.
- `lane_stb` and `el`=0 always coincide; `el`=0 is never asserted without a strobe.

## Structure
- Shared package `dispatch_pkg`:
  - `SEL_Y1`=01, `SEL_Y2`=10, `SEL_Y3`=11, `SEL_Y4`=00.
  - `dest_to_sel` function.
  - FSM state typedef (IDLE/DRIVE/BLOCK).
- One sub-module, `sync_fifo` (DW+2 wide, DEPTH entries, `full`/`empty`/`count`). The dispatcher wraps it with the FSM and output registers.

## Test plan
- Reset mid-traffic: assert `rst` during DRIVE → `el`=1, `lane_stb`=0000 the same cycle; after release, `count`=0 and `in_rdy`=1.
- Single word 0xA5A5, dest 3, all lanes ready → one cycle later `el`=0, `sel`=00, `lane_stb`=1000, `dout`=0xA5A5; next cycle `el`=1.
- Four words, dests 0,1,2,3, pushed back-to-back → sel sequence 01,10,11,00 on consecutive cycles with strobes 0001,0010,0100,1000; `count` peaks at 1.
- `lane_rdy`=1101, push dest 1 then dest 0 → BLOCK with `el`=1. The dest-0 word is not dispatched while the dest-1 word is blocked. Raising `lane_rdy[1]` dispatches dest 1 then dest 0 in order.
- Fill with `lane_rdy`=0000: after 4 pushes `in_rdy`=0 and a 5th `in_vld` is not accepted. Releasing the lanes drains 4 words and pointer wrap preserves order.
- Flush with 3 words queued while an input word is presented → next edge `count`=0, no strobe fires, and the presented word is not accepted.
